// File: rtl/regfile_32x32_sync.sv
// -----------------------------------------------------------------------------
// regfile_32x32_sync
//
// General-purpose register file for the datapath. It has 2**ADDR_WIDTH entries
// of DATA_WIDTH bits, two registered read ports and one write port.
//
// Entry 0 is the zero register. It always reads 0, writes to it are discarded,
// and it has no storage behind it.
//
// After reset a clear sequencer zeroes entries 1..DEPTH-1, one entry per cycle.
// Busy is high while the sweep runs. During the sweep, external writes are
// dropped and both read outputs are held at 0.
//
// Ports:
//   Clk    in   1           clock; all state changes on the rising edge
//   Rst    in   1           synchronous, active-high reset
//   Ard1   in   ADDR_WIDTH  read address, port 1
//   Ard2   in   ADDR_WIDTH  read address, port 2
//   Awr    in   ADDR_WIDTH  write address
//   Din    in   DATA_WIDTH  write data
//   WrEn   in   1           write enable
//   Dout1  out  DATA_WIDTH  registered read data, port 1 (latency 1)
//   Dout2  out  DATA_WIDTH  registered read data, port 2 (latency 1)
//   Busy   out  1           high while the clear sweep runs
// -----------------------------------------------------------------------------
module regfile_32x32_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [ADDR_WIDTH-1:0] Ard1,
    input  logic [ADDR_WIDTH-1:0] Ard2,
    input  logic [ADDR_WIDTH-1:0] Awr,
    input  logic [DATA_WIDTH-1:0] Din,
    input  logic                  WrEn,
    output logic [DATA_WIDTH-1:0] Dout1,
    output logic [DATA_WIDTH-1:0] Dout2,
    output logic                  Busy
);

    localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   clr_ptr_reg;
    logic                    busy_reg;

    // Storage for entries 1..DEPTH-1 only. Entry 0 is synthesised as a
    // constant on the read side, so no flop or RAM word can ever hold a
    // non-zero value for it.
    logic [DATA_WIDTH-1:0]   mem [1:DEPTH-1];

    // The single physical write port is shared. The sweep owns it in CLEAR,
    // and write-back owns it in RUN. A reset edge writes nothing.
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_ptr_reg;
        wr_data = '0;
        if (!Rst) begin
            if (state_reg == CLEAR) begin
                wr_en = 1'b1;
            end else if (WrEn && (Awr != '0)) begin
                wr_en   = 1'b1;
                wr_addr = Awr;
                wr_data = Din;
            end
        end
    end

    // wr_addr is never 0 here: clr_ptr_reg starts at 1, and Awr==0 is filtered.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Clear sequencer. The pointer parks at the last entry rather than
    // wrapping, so it never revisits entry 0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= FIRST_ADDR;
            busy_reg    <= 1'b1;
        end else if (state_reg == CLEAR) begin
            if (clr_ptr_reg == LAST_ADDR) begin
                state_reg <= RUN;
                busy_reg  <= 1'b0;
            end else begin
                clr_ptr_reg <= clr_ptr_reg + FIRST_ADDR;
            end
        end
    end

    // Two identical read ports. Precedence: zero register, then same-edge
    // forwarding of the write-back value, then the stored contents.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] rd_addr;
            logic [DATA_WIDTH-1:0] dout_reg;

            assign rd_addr = (gi == 0) ? Ard1 : Ard2;

            always_ff @(posedge Clk) begin
                if (Rst || (state_reg == CLEAR)) begin
                    dout_reg <= '0;
                end else if (rd_addr == '0) begin
                    dout_reg <= '0;
                end else if (BYPASS_EN && WrEn && (Awr == rd_addr)) begin
                    dout_reg <= Din;
                end else begin
                    dout_reg <= mem[rd_addr];
                end
            end
        end
    endgenerate

    assign Dout1 = g_rd[0].dout_reg;
    assign Dout2 = g_rd[1].dout_reg;
    assign Busy  = busy_reg;

endmodule

// File: doc/regfile_32x32_sync.md
Name: regfile_32x32_sync

Overview:
- 32-entry x 32-bit general-purpose register file for the datapath.
- Entry 0 is the zero register: always reads 0, and writes to it are discarded. Entries 1..31 are writable storage.
- Two registered read ports feed operand latches (decode to execute); one write port is driven by write-back.
- Hardware clear sequencer: after reset, zeroes entries 1..31, one per cycle, and reports Busy until done.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH.
- BYPASS_EN, 1, 1 = same-cycle write-to-read forwarding; 0 = read returns the old contents.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Ard1  in  ADDR_WIDTH  read address, port 1.
- Ard2  in  ADDR_WIDTH  read address, port 2.
- Awr  in  ADDR_WIDTH  write address.
- Din  in  DATA_WIDTH  write data.
- WrEn  in  1  write enable.
- Dout1  out  DATA_WIDTH  registered read data, port 1.
- Dout2  out  DATA_WIDTH  registered read data, port 2.
- Busy  out  1  high while the clear sequence runs; writes and reads are not serviced.

Behaviour:
- One clock, synchronous active-high reset; no asynchronous paths.
- State machine has two states, CLEAR and RUN.
- Reset: Rst=1 at an edge gives state=CLEAR, clr_ptr=1, Busy=1, Dout1=0, Dout2=0. This applies every cycle Rst is held.
- Storage is not written on reset edges. Entries are only zeroed by the sweep.
- CLEAR, each edge with Rst=0:
  - mem[clr_ptr] <= 0; clr_ptr <= clr_ptr+1.
  - When clr_ptr==31 at the edge, the next state is RUN and Busy <= 0 on that same edge.
  - After Rst falls, Busy stays high for exactly 31 edges.
- CLEAR, ports: WrEn is ignored (write dropped, no queuing). Dout1 and Dout2 are held at 0.
- Reset mid-sweep: the sweep restarts from entry 1 and takes the full 31 cycles again.
- RUN, read latency 1: the address presented before edge k appears on Dout after edge k.
  - DoutN <= 0 if ArdN==0.
  - Else DoutN <= Din if BYPASS_EN && WrEn && Awr==ArdN.
  - Else DoutN <= mem[ArdN].
- RUN, write: WrEn=1 and Awr!=0 gives mem[Awr] <= Din on the edge. WrEn=1 with Awr==0 is a no-op.
- Simultaneous events:
  - Both read ports may hit the same address, including the write address; both get identical data.
  - With BYPASS_EN=0, a same-edge read returns the pre-write contents, and the new value is visible one cycle later.
- Width rules: there is no arithmetic on data. clr_ptr is ADDR_WIDTH bits wide and never wraps, because the sweep stops at 31.
- Entry 0 holds no storage. A physical flop, if present, must stay 0.
- Outputs hold their last value when addresses are unchanged and there is no write to the addressed entry.

Test Plan:
- Reset/clear: Rst=1 for 2 cycles, then 0. Busy=1 for 31 edges after release, then 0. Read of every address 0..31 returns 0x00000000.
- Zero register: in RUN, WrEn=1, Awr=0, Din=0xDEADBEEF; next cycle Ard1=Ard2=0. Dout1=Dout2=0x00000000.
- Write/read: write 0x12345678 to entry 5 and 0xCAFEF00D to entry 31, then Ard1=5, Ard2=31. After one edge, Dout1=0x12345678 and Dout2=0xCAFEF00D.
- Bypass: same edge WrEn=1, Awr=7, Din=0xA5A5A5A5, Ard1=Ard2=7. BYPASS_EN=1 gives 0xA5A5A5A5 on both ports. BYPASS_EN=0 gives the prior value (0 after clear), and 0xA5A5A5A5 on the following cycle.
- Write during Busy: WrEn=1, Awr=3, Din=0x1 at the 10th clear cycle. After Busy falls, entry 3 reads 0x00000000.
- Reset mid-sweep: assert Rst at the 15th clear cycle after preloading entry 20=0xFFFFFFFF before the first reset. Busy stays high 31 more edges after release, and entry 20 reads 0.
